// File: rtl/symbiface_pkg.sv
// Shared constants and types for the SYMBiFACE II mouse scheduler.
// Record tags, per-read movement clamp limits and the idle byte.
package symbiface_pkg;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_X    = 2'b01;
  localparam logic [1:0] TAG_Y    = 2'b10;
  localparam logic [1:0] TAG_BTN  = 2'b11;

  localparam int MOVE_MAX = 31;
  localparam int MOVE_MIN = -32;
  localparam int MOVE_W   = 6;
  localparam int DELTA_W  = 9;

  localparam logic [7:0] REC_IDLE = 8'hFF;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_e;

endpackage

// File: rtl/symbiface_sat_acc.sv
// One saturating signed motion accumulator: adds a 9-bit packet delta and
// subtracts the clamped amount just reported, saturating in a single cycle.
module symbiface_sat_acc
  import symbiface_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     add_en,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                     drain_en,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [MOVE_W-1:0] m,
  output logic                     nonzero
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(1 << (ACC_W - 1)));
  localparam logic signed [ACC_W-1:0] M_MAX   = ACC_W'(MOVE_MAX);
  localparam logic signed [ACC_W-1:0] M_MIN   = ACC_W'(MOVE_MIN);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] acc_ext, m_ext, d_ext, sum;

  always_comb begin
    if (acc_q > M_MAX) begin
      m = MOVE_W'(MOVE_MAX);
    end else if (acc_q < M_MIN) begin
      m = MOVE_W'(MOVE_MIN);
    end else begin
      m = acc_q[MOVE_W-1:0];
    end
  end

  // One extra bit of headroom covers acc - m + delta for any operands.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
    m_ext   = drain_en ? {{(SUM_W - MOVE_W){m[MOVE_W-1]}}, m} : '0;
    d_ext   = add_en ? {{(SUM_W - DELTA_W){delta[DELTA_W-1]}}, delta} : '0;
    sum     = acc_ext - m_ext + d_ext;
    if (sum > ACC_MAX) begin
      acc_d = ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      acc_d = ACC_MIN[ACC_W-1:0];
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc     = acc_q;
  assign nonzero = |acc_q;

endmodule

// File: rtl/symbiface_mouse_sched.sv
// Mouse motion accumulator and read scheduler: integrates PS/2 packets and
// drains button/axis state as tagged bytes on each CPU read edge.
module symbiface_mouse_sched
  import symbiface_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        pending
);

  logic        toggle_q;
  logic        rd_q;
  logic [2:0]  btn_cur_q, btn_cur_d;
  logic [2:0]  btn_rep_q, btn_rep_d;
  logic        btn_pend_q, btn_pend_d;
  axis_e       last_axis_q, last_axis_d;
  logic [7:0]  dout_q, dout_d;
  logic        pending_q, pending_d;

  logic                     pkt_valid, rd_edge, pick_y;
  logic                     drain_x, drain_y;
  logic signed [DELTA_W-1:0] dx, dy;
  logic [2:0]               pkt_btn;
  logic signed [ACC_W-1:0]  acc_x, acc_y;
  logic signed [MOVE_W-1:0] m_x, m_y;
  logic                     x_nz, y_nz;
  logic [7:0]               rec;
  logic                     unused_bits;

  assign pkt_valid   = ps2_mouse[24] ^ toggle_q;
  assign dx          = {ps2_mouse[4], ps2_mouse[15:8]};
  assign dy          = {ps2_mouse[5], ps2_mouse[23:16]};
  assign pkt_btn     = ps2_mouse[2:0];
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3]};
  assign rd_edge     = rd & ~rd_q;
  // After an X record prefer Y, after a Y record prefer X.
  assign pick_y      = (last_axis_q == AXIS_X) ? y_nz : ~x_nz;

  symbiface_sat_acc #(.ACC_W(ACC_W)) u_acc_x (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .add_en   (pkt_valid),
    .delta    (dx),
    .drain_en (drain_x),
    .acc      (acc_x),
    .m        (m_x),
    .nonzero  (x_nz)
  );

  symbiface_sat_acc #(.ACC_W(ACC_W)) u_acc_y (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .add_en   (pkt_valid),
    .delta    (dy),
    .drain_en (drain_y),
    .acc      (acc_y),
    .m        (m_y),
    .nonzero  (y_nz)
  );

  always_comb begin
    btn_cur_d   = btn_cur_q;
    btn_rep_d   = btn_rep_q;
    btn_pend_d  = btn_pend_q;
    last_axis_d = last_axis_q;
    drain_x     = 1'b0;
    drain_y     = 1'b0;
    rec         = {TAG_NONE, 6'b000000};

    if (rd_edge) begin
      if (btn_pend_q) begin
        rec        = {TAG_BTN, 3'b000, btn_cur_q};
        btn_rep_d  = btn_cur_q;
        btn_pend_d = 1'b0;
      end else if (x_nz || y_nz) begin
        if (pick_y) begin
          rec     = {TAG_Y, m_y};
          drain_y = 1'b1;
        end else begin
          rec     = {TAG_X, m_x};
          drain_x = 1'b1;
        end
        last_axis_d = (last_axis_q == AXIS_X) ? AXIS_Y : AXIS_X;
      end
    end

    // Compared against the value reported this cycle, so a same-cycle read
    // followed by a change still re-arms the button record.
    if (pkt_valid) begin
      btn_cur_d = pkt_btn;
      if (pkt_btn != btn_rep_d) begin
        btn_pend_d = 1'b1;
      end
    end

    if (!rd) begin
      dout_d = REC_IDLE;
    end else if (rd_edge) begin
      dout_d = rec;
    end else begin
      dout_d = dout_q;
    end

    pending_d = btn_pend_q | (acc_x != '0) | (acc_y != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q    <= ps2_mouse[24];
      rd_q        <= 1'b1;
      btn_cur_q   <= '0;
      btn_rep_q   <= '0;
      btn_pend_q  <= 1'b0;
      last_axis_q <= AXIS_X;
      dout_q      <= REC_IDLE;
      pending_q   <= 1'b0;
    end else begin
      toggle_q    <= ps2_mouse[24];
      rd_q        <= rd;
      btn_cur_q   <= btn_cur_d;
      btn_rep_q   <= btn_rep_d;
      btn_pend_q  <= btn_pend_d;
      last_axis_q <= last_axis_d;
      dout_q      <= dout_d;
      pending_q   <= pending_d;
    end
  end

  assign dout    = dout_q;
  assign pending = pending_q ^ (unused_bits & 1'b0);

endmodule

// File: tb/tb_symbiface_mouse_sched.sv
// Bench for symbiface_mouse_sched: directed scenarios plus random packets and
// reads checked against a behavioural model of the accumulators and buttons.
module tb_symbiface_mouse_sched;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic        rd;
  logic [7:0]  dout;
  logic        pending;

  always #5 clk_sys = ~clk_sys;

  symbiface_mouse_sched #(.ACC_W(10)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_mouse (ps2_mouse),
    .rd        (rd),
    .dout      (dout),
    .pending   (pending)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int         m_x, m_y;
  logic [2:0] m_cur, m_rep;
  bit         m_pend;
  bit         m_last_y;
  logic       tog = 1'b0;

  function automatic int sat_acc(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int clamp_move(input int v);
    if (v > 31) return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  function automatic logic [24:0] pkt(input int dx, input int dy, input logic [2:0] b, input logic t);
    logic [8:0] x9, y9;
    x9 = dx[8:0];
    y9 = dy[8:0];
    return {t, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, b};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_cur = '0; m_rep = '0; m_pend = 0; m_last_y = 0;
  endtask

  task automatic model_packet(input int dx, input int dy, input logic [2:0] b);
    m_x   = sat_acc(m_x + dx);
    m_y   = sat_acc(m_y + dy);
    m_cur = b;
    if (b != m_rep) m_pend = 1;
  endtask

  task automatic model_read(output logic [7:0] rec);
    int   mv;
    bit   use_y;
    logic [5:0] m6;
    if (m_pend) begin
      rec    = {5'b11000, m_cur};
      m_rep  = m_cur;
      m_pend = 0;
    end else if (m_x != 0 || m_y != 0) begin
      use_y = m_last_y ? (m_x == 0) : (m_y != 0);
      mv    = clamp_move(use_y ? m_y : m_x);
      m6    = mv[5:0];
      rec   = {(use_y ? 2'b10 : 2'b01), m6};
      if (use_y) m_y = m_y - mv; else m_x = m_x - mv;
      m_last_y = ~m_last_y;
    end else begin
      rec = 8'h00;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_packet(input int dx, input int dy, input logic [2:0] b);
    @(negedge clk_sys);
    tog       = ~tog;
    ps2_mouse = pkt(dx, dy, b, tog);
    model_packet(dx, dy, b);
  endtask

  task automatic do_read(input string tag, input bit lit_en, input logic [7:0] lit,
                         input bit with_pkt, input int dx, input int dy, input logic [2:0] b);
    logic [7:0] exp;
    @(negedge clk_sys);
    rd = 1'b1;
    model_read(exp);
    if (with_pkt) begin
      tog       = ~tog;
      ps2_mouse = pkt(dx, dy, b, tog);
      model_packet(dx, dy, b);
    end
    @(negedge clk_sys);
    chk(tag, dout, exp);
    if (lit_en) chk({tag, "_lit"}, dout, lit);
    @(negedge clk_sys);
    chk({tag, "_held"}, dout, exp);
    rd = 1'b0;
    @(negedge clk_sys);
    chk({tag, "_idle"}, dout, 8'hFF);
  endtask

  task automatic check_pend(input string tag);
    repeat (2) @(negedge clk_sys);
    chk(tag, {7'b0, pending}, {7'b0, (m_pend || m_x != 0 || m_y != 0)});
  endtask

  initial begin
    int         dx, dy, r;
    logic [2:0] b;

    reset = 1'b1; rd = 1'b0; ps2_mouse = '0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("reset_dout", dout, 8'hFF);
    chk("reset_pending", {7'b0, pending}, 8'h00);
    reset = 1'b0;

    // Empty read
    do_read("empty_read", 1, 8'h00, 0, 0, 0, 3'b000);
    check_pend("empty_pend");

    // dx = +100 drains as 31,31,31,7
    send_packet(100, 0, 3'b000);
    check_pend("dx100_pend");
    do_read("dx100_r0", 1, 8'h5F, 0, 0, 0, 3'b000);
    do_read("dx100_r1", 1, 8'h5F, 0, 0, 0, 3'b000);
    do_read("dx100_r2", 1, 8'h5F, 0, 0, 0, 3'b000);
    do_read("dx100_r3", 1, 8'h47, 0, 0, 0, 3'b000);
    do_read("dx100_r4", 1, 8'h00, 0, 0, 0, 3'b000);

    // Button record takes priority, then Y, then X
    send_packet(5, -3, 3'b000);
    send_packet(0, 0, 3'b001);
    check_pend("btn_pend");
    do_read("btn_r0", 1, 8'hC1, 0, 0, 0, 3'b000);
    do_read("btn_r1", 1, 8'hBD, 0, 0, 0, 3'b000);
    do_read("btn_r2", 1, 8'h45, 0, 0, 0, 3'b000);
    do_read("btn_r3", 1, 8'h00, 0, 0, 0, 3'b000);
    send_packet(0, 0, 3'b000);
    do_read("btn_release", 1, 8'hC0, 0, 0, 0, 3'b000);

    // Negative saturation then drain
    for (int i = 0; i < 20; i++) send_packet(-255, 0, 3'b000);
    check_pend("sat_pend");
    for (int i = 0; i < 16; i++) do_read("sat_drain", 1, 8'h60, 0, 0, 0, 3'b000);
    do_read("sat_empty", 1, 8'h00, 0, 0, 0, 3'b000);
    check_pend("sat_pend_clear");

    // Packet on the same cycle as the read edge
    send_packet(0, 40, 3'b000);
    do_read("simul_r0", 1, 8'h9F, 1, 0, 10, 3'b000);
    do_read("simul_r1", 1, 8'h93, 0, 0, 0, 3'b000);
    do_read("simul_r2", 1, 8'h00, 0, 0, 0, 3'b000);

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 9));
      dx = int'($urandom_range(0, 511)) - 256;
      dy = int'($urandom_range(0, 511)) - 256;
      if (r < 2) begin
        dx = dx / 16;
        dy = dy / 16;
      end
      b = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : m_cur;
      if (r < 5) send_packet(dx, dy, b);
      else if (r < 9) do_read("rand_read", 0, 8'h00, 0, 0, 0, 3'b000);
      else do_read("rand_simul", 0, 8'h00, 1, dx, dy, b);
      if (i % 20 == 19) check_pend("rand_pend");
    end

    // Reset mid-read with a toggle flip during reset
    @(negedge clk_sys);
    reset     = 1'b1;
    rd        = 1'b1;
    tog       = ~tog;
    ps2_mouse = pkt(50, 0, 3'b101, tog);
    repeat (2) @(negedge clk_sys);
    chk("reset_mid_read", dout, 8'hFF);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("rd_held_after_reset", dout, 8'hFF);
    chk("post_reset_pend", {7'b0, pending}, 8'h00);
    rd = 1'b0;
    do_read("post_reset_read", 1, 8'h00, 0, 0, 0, 3'b000);
    check_pend("post_reset_pend2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/symbiface_mouse_sched.md
# symbiface_mouse_sched

Motion accumulator and read scheduler for the SYMBiFACE II mouse port. Integrates every PS/2 mouse packet into per-axis signed accumulators so no movement is lost when the CPU polls slower than the mouse reports. On each CPU read of the mouse port it drains the accumulators and button state as tagged 8-bit records. Sits between the HPS PS/2 mouse bus and the CPU I/O read mux.

## Interface
- ACC_W, 10: accumulator width in bits, signed two's complement; range −2^(ACC_W−1) … 2^(ACC_W−1)−1.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ps2_mouse  in  25  [24] packet toggle, [23:16] dy low, [15:8] dx low, [5] dy sign, [4] dx sign, [2:0] buttons.
- rd  in  1  mouse-port read select, level; one CPU read per rising edge.
- dout  out  8  record byte; 8'hFF whenever rd is low.
- pending  out  1  high when a read would return a non-zero record.

## Operation
- Packet capture: a packet arrives when ps2_mouse[24] differs from its registered copy. Deltas are 9-bit signed {sign, low byte}, sign-extended to ACC_W+1 bits and added to acc_x / acc_y; result saturates to the ACC_W range. Buttons are latched into btn_cur; btn_pend is set when the new value differs from btn_rep (last reported).
- Read edge: rd high and registered rd low. One record is chosen by priority:
  - btn_pend → {2'b11, 3'b000, btn_cur}; btn_rep ← btn_cur, btn_pend ← 0.
  - else the next non-zero axis in round-robin order (last_axis flips after each axis record; Y preferred after reset). Y → {2'b10, m}, X → {2'b01, m}, with m = acc clamped to −32…+31 (6-bit). acc ← acc − m.
  - else 8'h00.
- Simultaneous packet and read edge: record computed from pre-packet values; next acc = sat(acc − m + delta); if packet buttons also change, btn_pend ← (new btn ≠ value just reported).
- Button change while a previous change is unreported: only the latest state is reported; intermediate states are dropped.
- pending = btn_pend | (acc_x ≠ 0) | (acc_y ≠ 0), registered.

## Timing
- dout registered: updated on the clock edge that detects the read edge, valid from the next cycle, held while rd stays high; the cycle after rd is sampled low, dout = 8'hFF.
- Packet-to-pending latency: 2 cycles after the toggle change reaches ps2_mouse.
- Reset values: dout = 8'hFF, pending = 0, acc_x = acc_y = 0, btn_cur = btn_rep = 0, btn_pend = 0, last_axis = X, registered rd = 1 (no read edge on the first cycle after reset).
- During reset the toggle copy tracks ps2_mouse[24] so no phantom packet after release; reset mid-read forces dout = 8'hFF immediately.
- Back-to-back reads need rd low for at least one cycle between them.

## Structure
- Package symbiface_pkg: TAG_NONE = 2'b00, TAG_X = 2'b01, TAG_Y = 2'b10, TAG_BTN = 2'b11, MOVE_MAX = 31, MOVE_MIN = −32, REC_IDLE = 8'hFF.
- Sub-module symbiface_sat_acc (one per axis): inputs add_en, delta (9-bit), drain_en; outputs acc, clamped m, nonzero. Performs the sign-extend, subtract, add and saturation in one cycle. The top holds edge detection, button tracking, round-robin arbiter and the output register.

## Test plan
- Reset then read with no packets → dout 8'h00, pending 0; rd low → dout 8'hFF.
- One packet dx = +100, dy = 0 → reads give 8'h5F, 8'h5F, 8'h5F, 8'h47 (31, 31, 31, 7), then 8'h00.
- Packet dx = +5, dy = −3, then buttons 3'b001 → reads give 8'hC1 (button), then 8'hBD (Y −3), then 8'h45 (X +5).
- 20 packets of dx = −255 with no reads → acc_x saturates at −512; 16 reads drain 8'h60 (−32) each, then 8'h00.
- Packet dy = +10 on the same cycle as the read edge with acc_y = 40 → read returns 8'h9F, acc_y = 19.
- Reset asserted with ps2_mouse[24] toggled during reset → no record after release; pending stays 0.
